n_bit_csa_adder: RTL and testbench

N_BIT_CSA_ADDER -- requirements
Module: n_bit_csa_adder

---
 rtl/csa_pkg.sv | 18 +
 rtl/csa_block.sv | 39 +++
 rtl/n_bit_csa_adder.sv | 124 ++++++++++++
 tb/tb_n_bit_csa_adder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared constants and helpers for the carry-select adder.
// Holds the default operand/block widths and the block-count function.
package csa_pkg;

  localparam int DEF_IN_DATAWIDTH = 4;
  localparam int DEF_BLOCK_WIDTH  = 2;

  // Number of carry-select blocks; the last one is narrower when width is not a multiple.
  function automatic int csa_nblocks(input int width, input int block_width);
    return (width + block_width - 1) / block_width;
  endfunction

  // Blocks 0..floor(nblocks/2) form the early stage when the pipeline register is enabled.
  function automatic int csa_split_blocks(input int nblocks);
    return (nblocks / 2 + 1 > nblocks) ? nblocks : nblocks / 2 + 1;
  endfunction

endpackage

// File: rtl/csa_block.sv
// One carry-select block: two ripple adders (carry-in 0 and 1) and a 2:1 select on c_in.
// With DUAL=0 the block is a single ripple adder fed directly by c_in (used for block 0).
module csa_block #(
  parameter int W    = 2,
  parameter bit DUAL = 1'b1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] s,
  output logic         c_out
);

  // Returns {carry_out, sum}.
  function automatic logic [W:0] ripple(input logic [W-1:0] x,
                                        input logic [W-1:0] y,
                                        input logic         ci);
    logic [W:0] r;
    logic       c;
    c = ci;
    for (int i = 0; i < W; i++) begin
      r[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    r[W] = c;
    return r;
  endfunction

  if (DUAL) begin : g_dual
    logic [W:0] r0;
    logic [W:0] r1;
    assign r0 = ripple(a, b, 1'b0);
    assign r1 = ripple(a, b, 1'b1);
    assign {c_out, s} = c_in ? r1 : r0;
  end else begin : g_single
    assign {c_out, s} = ripple(a, b, c_in);
  end

endmodule

// File: rtl/n_bit_csa_adder.sv
// Registered carry-select adder: sum = in1 + in2 + cin, MSB of sum is the carry-out.
// Define N_BIT_CSA_ADDER_PIPE_EN to add a mid-chain register (latency 2 instead of 1).
module n_bit_csa_adder
  import csa_pkg::*;
#(
  parameter int IN_DATAWIDTH  = DEF_IN_DATAWIDTH,
  parameter int OUT_DATAWIDTH = IN_DATAWIDTH + 1,
  parameter int BLOCK_WIDTH   = DEF_BLOCK_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [IN_DATAWIDTH-1:0]  in1,
  input  logic [IN_DATAWIDTH-1:0]  in2,
  input  logic                     cin,
  output logic [OUT_DATAWIDTH-1:0] sum,
  output logic                     out_valid
);

  localparam int NBLK = csa_nblocks(IN_DATAWIDTH, BLOCK_WIDTH);

  logic [NBLK:0]            carry;
  logic [IN_DATAWIDTH-1:0]  blk_s;
  logic [OUT_DATAWIDTH-1:0] res;
  logic                     res_v;

  assign carry[0] = cin;

`ifdef N_BIT_CSA_ADDER_PIPE_EN
  localparam int SPLIT = csa_split_blocks(NBLK);
  localparam int LOW_W = (SPLIT * BLOCK_WIDTH > IN_DATAWIDTH) ? IN_DATAWIDTH
                                                              : SPLIT * BLOCK_WIDTH;

  logic                    p_v;
  logic                    p_c;
  logic [LOW_W-1:0]        p_lo;
  logic [IN_DATAWIDTH-1:0] p_a;
  logic [IN_DATAWIDTH-1:0] p_b;

  // NOTE: flops use non-blocking (<=) so every register samples pre-edge values;
  // blocking (=) is reserved for combinational chaining such as the ripple function.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_v  <= 1'b0;
      p_c  <= 1'b0;
      p_lo <= '0;
      p_a  <= '0;
      p_b  <= '0;
    end else begin
      p_v <= in_valid;
      if (in_valid) begin
        p_lo <= blk_s[LOW_W-1:0];
        p_c  <= carry[SPLIT];
        p_a  <= in1;
        p_b  <= in2;
      end
    end
  end
`endif

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    localparam int LO = k * BLOCK_WIDTH;
    localparam int BW = (k == NBLK - 1) ? IN_DATAWIDTH - LO : BLOCK_WIDTH;

    logic [BW-1:0] a_k;
    logic [BW-1:0] b_k;
    logic          c_k;

`ifdef N_BIT_CSA_ADDER_PIPE_EN
    if (k >= SPLIT) begin : g_late
      assign a_k = p_a[LO +: BW];
      assign b_k = p_b[LO +: BW];
      if (k == SPLIT) begin : g_first
        assign c_k = p_c;
      end else begin : g_rest
        assign c_k = carry[k];
      end
    end else begin : g_early
      assign a_k = in1[LO +: BW];
      assign b_k = in2[LO +: BW];
      assign c_k = carry[k];
    end
`else
    assign a_k = in1[LO +: BW];
    assign b_k = in2[LO +: BW];
    assign c_k = carry[k];
`endif

    csa_block #(
      .W    (BW),
      .DUAL (k != 0)
    ) u_blk (
      .a     (a_k),
      .b     (b_k),
      .c_in  (c_k),
      .s     (blk_s[LO +: BW]),
      .c_out (carry[k+1])
    );
  end

`ifdef N_BIT_CSA_ADDER_PIPE_EN
  // When the early stage covers every block, the registered carry is the carry-out.
  if (SPLIT == NBLK) begin : g_res_full
    assign res = {p_c, p_lo};
  end else begin : g_res_split
    assign res = {carry[NBLK], blk_s[IN_DATAWIDTH-1:LOW_W], p_lo};
  end
  assign res_v = p_v;
`else
  assign res   = {carry[NBLK], blk_s};
  assign res_v = in_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= res_v;
      if (res_v) sum <= res;
    end
  end

endmodule

// File: tb/tb_n_bit_csa_adder.sv
// Self-checking bench for n_bit_csa_adder: default 4/2 instance plus an uneven 7/3 instance.
// Latency follows N_BIT_CSA_ADDER_PIPE_EN (1 cycle without it, 2 with it).
module tb_n_bit_csa_adder;

`ifdef N_BIT_CSA_ADDER_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NRND = 1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in1, in2;
  logic       cin;
  logic [4:0] sum;
  logic       out_valid;

  logic       v7;
  logic [6:0] a7, b7;
  logic       c7;
  logic [7:0] s7;
  logic       ov7;

  logic [7:0] exp7 [NRND];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  n_bit_csa_adder u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in1       (in1),
    .in2       (in2),
    .cin       (cin),
    .sum       (sum),
    .out_valid (out_valid)
  );

  n_bit_csa_adder #(
    .IN_DATAWIDTH (7),
    .BLOCK_WIDTH  (3)
  ) u_dut7 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v7),
    .in1       (a7),
    .in2       (b7),
    .cin       (c7),
    .sum       (s7),
    .out_valid (ov7)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Single transaction, then one idle cycle.
  task automatic one_shot(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic c, input logic [4:0] exp);
    in_valid = 1'b1;
    in1      = a;
    in2      = b;
    cin      = c;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check(tag, 64'(sum), 64'(exp));
    @(negedge clk);
  endtask

  logic [3:0] st_a [3] = '{4'd1, 4'd7, 4'd9};
  logic [3:0] st_b [3] = '{4'd2, 4'd8, 4'd9};
  logic       st_c [3] = '{1'b0, 1'b1, 1'b0};
  logic [4:0] st_s [3] = '{5'd3, 5'd16, 5'd18};

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in1      = '0;
    in2      = '0;
    cin      = 1'b0;
    v7       = 1'b0;
    a7       = '0;
    b7       = '0;
    c7       = 1'b0;

    #1;
    check("reset_sum", 64'(sum), 64'd0);
    check("reset_valid", 64'(out_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_valid", 64'(out_valid), 64'd0);

    for (int i = 0; i < 16; i++)
      one_shot($sformatf("sweep_%0d", i), 4'(i), 4'(i), 1'b0, 5'(2 * i));

    one_shot("carry_15_0_1", 4'd15, 4'd0, 1'b1, 5'd16);
    one_shot("carry_15_15_1", 4'd15, 4'd15, 1'b1, 5'd31);
    one_shot("zero", 4'd0, 4'd0, 1'b0, 5'd0);
    one_shot("mixed_5_10_0", 4'd5, 4'd10, 1'b0, 5'd15);

    for (int t = 0; t < 3 + LAT + 1; t++) begin
      if (t >= LAT && t < LAT + 3) begin
        check($sformatf("stream_valid_%0d", t - LAT), 64'(out_valid), 64'd1);
        check($sformatf("stream_sum_%0d", t - LAT), 64'(sum), 64'(st_s[t - LAT]));
      end else if (t == LAT + 3) begin
        check("stream_end_valid", 64'(out_valid), 64'd0);
      end
      if (t < 3) begin
        in_valid = 1'b1;
        in1      = st_a[t];
        in2      = st_b[t];
        cin      = st_c[t];
      end else begin
        in_valid = 1'b0;
        in1      = 4'd3;
        in2      = 4'd3;
      end
      @(negedge clk);
    end

    for (int t = 0; t < 5; t++) begin
      check($sformatf("hold_sum_%0d", t), 64'(sum), 64'd18);
      check($sformatf("hold_valid_%0d", t), 64'(out_valid), 64'd0);
      @(negedge clk);
    end

    in_valid = 1'b1;
    in1      = 4'd5;
    in2      = 4'd6;
    cin      = 1'b0;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_valid", 64'(out_valid), 64'd0);
    #1;
    rst_n = 1'b1;
    for (int t = 0; t < LAT + 2; t++) begin
      @(negedge clk);
      check($sformatf("postrst_valid_%0d", t), 64'(out_valid), 64'd0);
      check($sformatf("postrst_sum_%0d", t), 64'(sum), 64'd0);
    end
    one_shot("postrst_first", 4'd3, 4'd4, 1'b1, 5'd8);

    for (int t = 0; t < NRND + LAT; t++) begin
      if (t >= LAT) begin
        check($sformatf("rnd7_valid_%0d", t - LAT), 64'(ov7), 64'd1);
        check($sformatf("rnd7_sum_%0d", t - LAT), 64'(s7), 64'(exp7[t - LAT]));
      end
      if (t < NRND) begin
        if (t == 0) begin
          a7 = 7'd127; b7 = 7'd127; c7 = 1'b1;
        end else if (t == 1) begin
          a7 = 7'd0; b7 = 7'd0; c7 = 1'b0;
        end else begin
          a7 = 7'($urandom);
          b7 = 7'($urandom);
          c7 = 1'($urandom);
        end
        exp7[t] = {1'b0, a7} + {1'b0, b7} + {7'd0, c7};
        v7      = 1'b1;
      end else begin
        v7 = 1'b0;
      end
      @(negedge clk);
    end
    check("rnd7_end_valid", 64'(ov7), 64'd0);
    check("rnd7_boundary_first", 64'(exp7[0]), 64'd255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
